mnist_frame_sequencer: RTL and testbench
========================================

MNIST_FRAME_SEQUENCER -- requirements
Module: mnist_frame_sequencer

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 16, means 4-pixel words per frame (64 pixels at 2 bits each).
REQ-002 Parameter TIMEOUT_CYCLES, default 4095, means the maximum number of WAIT cycles before a core timeout.
REQ-003 Port clk, input, width 1, is the single clock; all logic SHALL be rising-edge.
REQ-004 Port rst_n, input, width 1, is the reset: asynchronous, active-low.
REQ-005 Port in_valid, input, width 1, means the upstream pixel word is valid.
REQ-006 Port in_ready, output, width 1, means the sequencer accepts the word this cycle.
REQ-007 Port in_data, input, width 8, carries 4 pixels: [7:6]=px3, [5:4]=px2, [3:2]=px1, [1:0]=px0.
REQ-008 Port core_start, output, width 1, is the start strobe to the inference core.
REQ-009 Port core_pixels, output, width 8, is the pixel word driven to the core.
REQ-010 Port core_done, input, width 1, means the core has finished and its prediction is valid.
REQ-011 Port core_busy, input, width 1, means the core is computing.
REQ-012 Port core_prediction, input, width 4, is the core class output.
REQ-013 Port res_valid, output, width 1, means a result is held for downstream.
REQ-014 Port res_ready, input, width 1, means downstream accepts the result.
REQ-015 Port res_class, output, width 4, is the predicted class 0-9, or 4'hF on timeout.
REQ-016 Port res_timeout, output, width 1, means the held result came from a timeout.
REQ-017 Port frame_count, output, width 8, counts completed results and wraps 255->0.

Function
REQ-018 FSM states SHALL be LOAD, STREAM, WAIT and RESULT.
REQ-019 LOAD: in_ready=1; each in_valid&in_ready handshake writes in_data to buffer[wr_idx] and increments wr_idx.
REQ-020 LOAD: the handshake at wr_idx=WORDS_PER_FRAME-1 SHALL reset wr_idx to 0 and move to STREAM on the next cycle.
REQ-021 STREAM: for exactly WORDS_PER_FRAME consecutive cycles, core_pixels=buffer[k] for k=0..15.
REQ-022 STREAM: core_start=1 only on the k=0 cycle.
REQ-023 Latency: the first STREAM cycle (core_start=1) SHALL be the cycle immediately after the last LOAD handshake.
REQ-024 After k=15 the FSM SHALL move to WAIT; in_ready=0 in STREAM, WAIT and RESULT.
REQ-025 WAIT: a 12-bit timer SHALL start from 0 and increment each cycle.
REQ-026 WAIT: core_done is ignored on the first WAIT cycle, which masks a stale done level from the previous frame.
REQ-027 WAIT: core_done=1 on a later cycle SHALL capture core_prediction into res_class, set res_timeout=0 and enter RESULT.
REQ-028 WAIT: if the timer reaches TIMEOUT_CYCLES with no done, res_class=4'hF, res_timeout=1, and the FSM enters RESULT.
REQ-029 If core_done and timeout occur on the same cycle, done SHALL win.
REQ-030 RESULT: res_valid=1 with res_class and res_timeout held stable until res_ready=1.
REQ-031 RESULT: on res_valid&res_ready, frame_count increments and the FSM enters LOAD on the next cycle.
REQ-032 res_ready=1 on the first RESULT cycle SHALL complete the transfer in one cycle.
REQ-033 core_pixels SHALL be 8'h00 outside STREAM.
REQ-034 core_busy SHALL be used only for the debug assertion that it is 1 within 2 cycles after core_start.
REQ-035 Buffer contents are undefined after reset; a new frame fully overwrites the buffer.

Reset
REQ-036 rst_n low SHALL immediately force state=LOAD, wr_idx=0, timer=0, frame_count=0, res_class=0, res_timeout=0.
REQ-037 During reset, outputs SHALL be in_ready=1 (LOAD state), core_start=0, core_pixels=0, res_valid=0.
REQ-038 Reset mid-STREAM or mid-WAIT SHALL abandon the frame with no result; the core is reset by the same rst_n.

Structure
REQ-039 Package mnist_pkg SHALL hold WORDS_PER_FRAME, the pixel-word width (8), the class width (4), the TIMEOUT_CLASS=4'hF constant and the FSM state enum.
REQ-040 One sub-module, mnist_frame_buf, SHALL be used: a 16x8 register file with a 1-write port and an asynchronous 1-read port, no reset on storage.

Verification
REQ-041 Load 16 words 0x00..0x0F back-to-back -> core_start=1 with core_pixels=0x00 the cycle after word 15, then 0x01..0x0F on the next 15 cycles.
REQ-042 Core model raises done 3747 cycles after start with prediction 7, res_ready=1 -> res_valid for 1 cycle, res_class=7, res_timeout=0, frame_count=1.
REQ-043 Core never raises done -> after 4095 WAIT cycles res_valid=1, res_class=4'hF, res_timeout=1.
REQ-044 Hold res_ready=0 for 50 cycles -> res_class stable, in_ready=0, and no upstream words consumed.
REQ-045 in_valid toggled randomly during LOAD -> exactly 16 handshakes are accepted and streamed in order.
REQ-046 Assert rst_n=0 at STREAM k=8 -> core_start=0 and res_valid=0 immediately, then after release 16 new words produce a normal result.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and FSM state type for the MNIST frame sequencer.
package mnist_pkg;
  localparam int WORDS_PER_FRAME = 16;
  localparam int PIXEL_WORD_W = 8;
  localparam int CLASS_W = 4;
  localparam int TIMER_W = 12;
  localparam logic [CLASS_W-1:0] TIMEOUT_CLASS = 4'hF;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    WAIT,
    RESULT
  } seq_state_e;
endpackage

// File: rtl/mnist_frame_buf.sv
// Frame word store: one synchronous write port, one combinational read port.
// Storage is deliberately not reset; every frame overwrites all entries.
module mnist_frame_buf
  import mnist_pkg::*;
#(
  parameter int DEPTH = WORDS_PER_FRAME,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [PIXEL_WORD_W-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [PIXEL_WORD_W-1:0] rd_data
);
  logic [PIXEL_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/mnist_frame_sequencer.sv
// Collects one frame of pixel words, replays it to the inference core, waits
// for the core's answer (or a timeout) and hands the result downstream.
module mnist_frame_sequencer #(
  parameter int WORDS_PER_FRAME = mnist_pkg::WORDS_PER_FRAME,
  parameter int TIMEOUT_CYCLES  = 4095
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [mnist_pkg::PIXEL_WORD_W-1:0]    in_data,
  output logic                                  core_start,
  output logic [mnist_pkg::PIXEL_WORD_W-1:0]    core_pixels,
  input  logic                                  core_done,
  input  logic                                  core_busy,
  input  logic [mnist_pkg::CLASS_W-1:0]         core_prediction,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [mnist_pkg::CLASS_W-1:0]         res_class,
  output logic                                  res_timeout,
  output logic [7:0]                            frame_count,
  output mnist_pkg::seq_state_e                 dbg_state
);
  import mnist_pkg::*;

  localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and held data stays stable until taken.

  seq_state_e          state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [TIMER_W-1:0]  timer, timer_next;
  logic [CLASS_W-1:0]  res_class_next;
  logic                res_timeout_next;
  logic [PIXEL_WORD_W-1:0] buf_rd_data;
  logic                in_fire;
  logic                res_fire;

  assign in_fire   = in_valid && (state == LOAD);
  assign res_fire  = res_ready && (state == RESULT);
  assign dbg_state = state;

  // idx is the write pointer while loading and the replay pointer while streaming.
  mnist_frame_buf #(.DEPTH(WORDS_PER_FRAME)) u_buf (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_addr (idx),
    .wr_data (in_data),
    .rd_addr (idx),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    timer_next       = timer;
    res_class_next   = res_class;
    res_timeout_next = res_timeout;
    in_ready         = 1'b0;
    core_start       = 1'b0;
    core_pixels      = '0;
    res_valid        = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            state_next = STREAM;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      STREAM: begin
        core_start  = (idx == '0);
        core_pixels = buf_rd_data;
        if (idx == LAST_IDX) begin
          idx_next   = '0;
          timer_next = '0;
          state_next = WAIT;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      WAIT: begin
        timer_next = timer + TIMER_W'(1);
        // timer==0 is the first WAIT cycle: a done level left over from the
        // previous frame may still be visible there, so it is not trusted.
        if (core_done && (timer != '0)) begin
          res_class_next   = core_prediction;
          res_timeout_next = 1'b0;
          state_next       = RESULT;
        end else if (timer == TIMER_LAST) begin
          res_class_next   = TIMEOUT_CLASS;
          res_timeout_next = 1'b1;
          state_next       = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      idx         <= '0;
      timer       <= '0;
      res_class   <= '0;
      res_timeout <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      timer       <= timer_next;
      res_class   <= res_class_next;
      res_timeout <= res_timeout_next;
      if (res_fire) frame_count <= frame_count + 8'd1;
    end
  end

  // The core must acknowledge a start by going busy within two cycles.
  core_busy_after_start: assert property (
    @(posedge clk) disable iff (!rst_n) core_start |-> ##[1:2] core_busy
  );
endmodule

// File: tb/tb_mnist_frame_sequencer.sv
// Bench for mnist_frame_sequencer: directed vector table, randomized frames
// against a timing/result model, and a reset-mid-stream sequence.
module tb_mnist_frame_sequencer;
  localparam int WPF     = 16;
  localparam int TIMEOUT = 4095;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       core_start;
  logic [7:0] core_pixels;
  logic       core_done;
  logic       core_busy;
  logic [3:0] core_prediction;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_class;
  logic       res_timeout;
  logic [7:0] frame_count;
  mnist_pkg::seq_state_e dbg_state;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int s_cyc = 0;
  int core_delay = 0;
  int core_cnt = 0;
  logic [3:0] core_pred = 4'd0;
  logic [7:0] exp_frames = 8'd0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         ramp;
    bit         gappy;
    int         delay;
    logic [3:0] pred;
    int         hold;
    logic [3:0] exp_class;
    bit         exp_to;
    int         exp_lat;
  } vec_t;
  vec_t vecs[7];

  mnist_frame_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .core_start      (core_start),
    .core_pixels     (core_pixels),
    .core_done       (core_done),
    .core_busy       (core_busy),
    .core_prediction (core_prediction),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_class       (res_class),
    .res_timeout     (res_timeout),
    .frame_count     (frame_count),
    .dbg_state       (dbg_state)
  );

  // clock / reset-independent bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: busy the cycle after start, done visible core_delay cycles
  // after start (0 = never) and held until the next start.
  assign core_prediction = core_pred;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else if (core_start) begin
      core_busy <= 1'b1;
      core_done <= 1'b0;
      core_cnt  <= 1;
    end else if (core_busy) begin
      if (core_delay != 0 && core_cnt >= core_delay - 1) begin
        core_done <= 1'b1;
        core_busy <= 1'b0;
      end
      core_cnt <= core_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result rules: the first trusted done is on WAIT cycle 2 (start+WPF+1) or
  // later; WAIT lasts at most TIMEOUT cycles; result shows the cycle after.
  function automatic void model_result(input int delay, input logic [3:0] pred,
                                       output logic [3:0] c, output bit to, output int lat);
    int seen;
    seen = (delay == 0) ? 32'h3fff_ffff : ((delay < WPF + 1) ? WPF + 1 : delay);
    if (seen <= WPF + TIMEOUT - 1) begin
      c = pred; to = 1'b0; lat = seen + 1;
    end else begin
      c = 4'hF; to = 1'b1; lat = WPF + TIMEOUT;
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that took word 15.
  task automatic load_frame(input bit ramp, input bit gappy);
    logic [7:0] w[16];
    int n;
    int guard;
    for (int i = 0; i < WPF; i++) begin
      w[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
      exp_q.push_back(w[i]);
    end
    n = 0;
    guard = 0;
    while (n < WPF && guard < 400) begin
      in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? w[n] : 8'($urandom_range(0, 255));
      @(negedge clk);
      if (guard == 0) check("load_in_ready", 32'(in_ready), 32'd1);
      if (in_valid && in_ready) n++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    check("load_handshakes", n, WPF);
  endtask

  task automatic stream_check();
    logic [7:0] w;
    for (int k = 0; k < WPF; k++) begin
      @(negedge clk);
      w = exp_q.pop_front();
      if (k == 0) s_cyc = cyc;
      check("stream_start", 32'(core_start), (k == 0) ? 32'd1 : 32'd0);
      check("stream_pixels", 32'(core_pixels), 32'(w));
      check("stream_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic result_check(input logic [3:0] ec, input bit eto, input int elat, input int hold);
    int guard;
    @(negedge clk);
    check("wait_pixels", 32'(core_pixels), 32'd0);
    check("wait_in_ready", 32'(in_ready), 32'd0);
    guard = 0;
    while (res_valid !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("result_valid", 32'(res_valid), 32'd1);
    check("result_latency", cyc - s_cyc, elat);
    check("result_class", 32'(res_class), 32'(ec));
    check("result_timeout", 32'(res_timeout), 32'(eto));
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = 8'($urandom_range(0, 255));
        core_pred = 4'($urandom_range(0, 15));
        @(negedge clk);
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_class", 32'(res_class), 32'(ec));
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      check("hold_release_valid", 32'(res_valid), 32'd1);
    end
    exp_frames = exp_frames + 8'd1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_result_valid", 32'(res_valid), 32'd0);
    check("post_result_in_ready", 32'(in_ready), 32'd1);
    check("frame_count", 32'(frame_count), 32'(exp_frames));
    @(posedge clk); #1;
  endtask

  task automatic run_vector(input bit ramp, input bit gappy, input int delay, input logic [3:0] pred,
                            input int hold, input logic [3:0] ec, input bit eto, input int elat);
    core_delay = delay;
    core_pred  = pred;
    res_ready  = (hold == 0);
    load_frame(ramp, gappy);
    stream_check();
    result_check(ec, eto, elat, hold);
  endtask

  initial begin
    #800000;
    failed++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mc;
    bit         mto;
    int         mlat;

    vecs[0] = '{ramp: 1, gappy: 0, delay: 3747, pred: 4'd7, hold: 0, exp_class: 4'd7, exp_to: 0, exp_lat: 3748};
    vecs[1] = '{ramp: 0, gappy: 0, delay: 0,    pred: 4'd3, hold: 0, exp_class: 4'hF, exp_to: 1, exp_lat: 4111};
    vecs[2] = '{ramp: 0, gappy: 1, delay: 40,   pred: 4'd9, hold: 50, exp_class: 4'd9, exp_to: 0, exp_lat: 41};
    vecs[3] = '{ramp: 0, gappy: 1, delay: 5,    pred: 4'd2, hold: 0, exp_class: 4'd2, exp_to: 0, exp_lat: 18};
    vecs[4] = '{ramp: 0, gappy: 0, delay: 4110, pred: 4'd5, hold: 0, exp_class: 4'd5, exp_to: 0, exp_lat: 4111};
    vecs[5] = '{ramp: 0, gappy: 0, delay: 17,   pred: 4'd0, hold: 1, exp_class: 4'd0, exp_to: 0, exp_lat: 18};
    vecs[6] = '{ramp: 0, gappy: 0, delay: 16,   pred: 4'd1, hold: 0, exp_class: 4'd1, exp_to: 0, exp_lat: 18};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_core_start", 32'(core_start), 32'd0);
    check("reset_core_pixels", 32'(core_pixels), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_class", 32'(res_class), 32'd0);
    check("reset_res_timeout", 32'(res_timeout), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(mnist_pkg::LOAD));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_vector(vecs[i].ramp, vecs[i].gappy, vecs[i].delay, vecs[i].pred, vecs[i].hold,
                 vecs[i].exp_class, vecs[i].exp_to, vecs[i].exp_lat);

    // Enough random frames to carry frame_count through 255 -> 0.
    for (int f = 0; f < 256 - 7; f++) begin
      int d;
      int h;
      logic [3:0] p;
      d = $urandom_range(1, 80);
      p = 4'($urandom_range(0, 9));
      h = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0;
      model_result(d, p, mc, mto, mlat);
      run_vector(1'b0, 1'($urandom_range(0, 1)), d, p, h, mc, mto, mlat);
    end
    check("frame_count_wrap", 32'(frame_count), 32'd0);

    // Reset in the middle of streaming abandons the frame.
    core_delay = 30;
    core_pred  = 4'd4;
    res_ready  = 1'b1;
    load_frame(1'b0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      logic [7:0] w;
      @(negedge clk);
      w = exp_q.pop_front();
      check("abort_stream_pixels", 32'(core_pixels), 32'(w));
      if (k < 8) begin
        @(posedge clk); #1;
      end
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_core_start", 32'(core_start), 32'd0);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_core_pixels", 32'(core_pixels), 32'd0);
    check("abort_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    exp_frames = 8'd0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_result(25, 4'd4, mc, mto, mlat);
    run_vector(1'b0, 1'b1, 25, 4'd4, 0, mc, mto, mlat);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
